// File: rtl/time_set_ctrl.sv
// time_set_ctrl
// Front-panel time-setting sequencer for the wall-clock counter chain.
// In RUN the chain counts freely. A set press freezes the chain, snapshots the
// live time and walks through hour / minute / second editing. A set press on
// the seconds field commits with a single-cycle parallel load. An esc press
// abandons editing without loading.
//
// Optional feature macro: AUTO_REPEAT_EN
//   When defined, a held inc/dec button auto-repeats: the first repeat comes
//   REPEAT_DELAY cycles after the edge step, and further repeats follow every
//   REPEAT_RATE cycles while the button stays held.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   btn_set/esc/inc/dec  synchronized button levels (rising edge = event)
//   cur_hora/min/seg  live time from the datapath (snapshotted on set)
//   run               count enable to the counter chain
//   load              one-cycle parallel-load strobe
//   ld_hora/min/seg/cs  load values (ld_cs is always 0)
//   sel               edited field: 0 none, 1 hour, 2 minute, 3 second
//   blink             display-blank toggle for the edited field
module time_set_ctrl #(
  parameter int BLINK_DIV    = 50,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set,
  input  logic       btn_esc,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hora,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_seg,
  output logic       run,
  output logic       load,
  output logic [4:0] ld_hora,
  output logic [5:0] ld_min,
  output logic [5:0] ld_seg,
  output logic [6:0] ld_cs,
  output logic [1:0] sel,
  output logic       blink
);

  typedef enum logic [2:0] {S_RUN, S_SET_H, S_SET_M, S_SET_S, S_COMMIT} state_t;

  localparam int BW = $clog2(BLINK_DIV);

  state_t        state, state_nxt;
  logic          set_q, esc_q, inc_q, dec_q;
  logic          set_ev, esc_ev, inc_ev, dec_ev;
  logic          in_set, nxt_in_set, xfer;
  logic          step_up, step_dn;
  logic [BW-1:0] blink_cnt;

  // Wrap-around step of one time field whose largest legal value is top.
  function automatic logic [5:0] step_field(input logic [5:0] v,
                                            input logic [5:0] top,
                                            input logic       up);
    if (up) return (v == top) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  assign set_ev = btn_set & ~set_q;
  assign esc_ev = btn_esc & ~esc_q;
  assign inc_ev = btn_inc & ~inc_q;
  assign dec_ev = btn_dec & ~dec_q;

  assign in_set     = (state == S_SET_H) || (state == S_SET_M) || (state == S_SET_S);
  assign nxt_in_set = (state_nxt == S_SET_H) || (state_nxt == S_SET_M) ||
                      (state_nxt == S_SET_S);
  // A set/esc event while editing always causes a transition; any step
  // coinciding with it is dropped.
  assign xfer = in_set & (set_ev | esc_ev);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset) state <= S_RUN;
    else        state <= state_nxt;
  end

  // Next-state logic. Esc has priority over set while editing.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    case (state)
      S_RUN:    if (set_ev) state_nxt = S_SET_H;
      S_SET_H:  if (esc_ev) state_nxt = S_RUN; else if (set_ev) state_nxt = S_SET_M;
      S_SET_M:  if (esc_ev) state_nxt = S_RUN; else if (set_ev) state_nxt = S_SET_S;
      S_SET_S:  if (esc_ev) state_nxt = S_RUN; else if (set_ev) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_RUN;
      default:  state_nxt = S_RUN;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    run  = 1'b0;
    load = 1'b0;
    sel  = 2'd0;
    case (state)
      S_RUN:    run  = 1'b1;
      S_SET_H:  sel  = 2'd1;
      S_SET_M:  sel  = 2'd2;
      S_SET_S:  sel  = 2'd3;
      S_COMMIT: load = 1'b1;
      default:  run  = 1'b1;
    endcase
  end

  assign ld_cs = 7'd0;

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1;

  logic [RW-1:0] rep_cnt;
  logic          rep_fast;  // first delay has elapsed; now stepping at REPEAT_RATE
  logic          hold_one;
  logic          rep_due;

  assign hold_one = btn_inc ^ btn_dec;
  assign rep_due  = in_set & hold_one & ~inc_ev & ~dec_ev &
                    (rep_cnt == (rep_fast ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1)));
  assign step_up  = in_set & ~xfer & ((inc_ev & ~dec_ev) | (rep_due & btn_inc));
  assign step_dn  = in_set & ~xfer & ((dec_ev & ~inc_ev) | (rep_due & btn_dec));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt  <= '0;
      rep_fast <= 1'b0;
    end else if (!in_set || (state_nxt != state) || !hold_one || inc_ev || dec_ev) begin
      rep_cnt  <= '0;
      rep_fast <= 1'b0;
    end else if (rep_due) begin
      rep_cnt  <= '0;
      rep_fast <= 1'b1;
    end else begin
      rep_cnt  <= rep_cnt + RW'(1);
    end
  end
`else
  assign step_up = in_set & ~xfer & inc_ev & ~dec_ev;
  assign step_dn = in_set & ~xfer & dec_ev & ~inc_ev;
`endif

  // Button history, snapshot/edit of the load values, and the blink divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set_q     <= 1'b0;
      esc_q     <= 1'b0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      ld_hora   <= 5'd0;
      ld_min    <= 6'd0;
      ld_seg    <= 6'd0;
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else begin
      set_q <= btn_set;
      esc_q <= btn_esc;
      inc_q <= btn_inc;
      dec_q <= btn_dec;

      // Out-of-range live values are captured as 0 so editing starts legal.
      if (state == S_RUN && set_ev) begin
        ld_hora <= (cur_hora > 5'd23) ? 5'd0 : cur_hora;
        ld_min  <= (cur_min  > 6'd59) ? 6'd0 : cur_min;
        ld_seg  <= (cur_seg  > 6'd59) ? 6'd0 : cur_seg;
      end else if (step_up || step_dn) begin
        case (state)
          S_SET_H: ld_hora <= 5'(step_field({1'b0, ld_hora}, 6'd23, step_up));
          S_SET_M: ld_min  <= step_field(ld_min, 6'd59, step_up);
          S_SET_S: ld_seg  <= step_field(ld_seg, 6'd59, step_up);
          default: ;
        endcase
      end

      // Entering a field or stepping it shows the value solidly before
      // resuming the blink cadence.
      if (!nxt_in_set) begin
        blink     <= 1'b0;
        blink_cnt <= '0;
      end else if ((state_nxt != state) || step_up || step_dn) begin
        blink     <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink     <= ~blink;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Button-driven controller that sequences time setting for the wall-clock counter chain (hours 0–23, minutes/seconds 0–59, centiseconds 0–99). In RUN it lets the chain count. On a set request it freezes the chain and snapshots the current time, then steps through hour/minute/second editing. On commit it emits a single-cycle parallel load. It sits between the synchronized front-panel buttons and the clock datapath, alongside the clock/stopwatch display mux.

## Interface
Parameters:
- BLINK_DIV, default 50, clk cycles per half-period of the field-blink output (≥2)
- REPEAT_DELAY, default 50, cycles a held inc/dec must stay high before the first auto-repeat step (only used with AUTO_REPEAT_EN)
- REPEAT_RATE, default 10, cycles between auto-repeat steps (only used with AUTO_REPEAT_EN)

Ports:
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low
- btn_set  in  1  level, already synchronized; rising edge advances the set sequence
- btn_esc  in  1  level, synchronized; rising edge aborts setting
- btn_inc  in  1  level, synchronized; rising edge increments the selected field
- btn_dec  in  1  level, synchronized; rising edge decrements the selected field
- cur_hora  in  5  live hour from the datapath
- cur_min  in  6  live minute
- cur_seg  in  6  live second
- run  out  1  count enable to the counter chain
- load  out  1  one-cycle parallel-load strobe
- ld_hora  out  5  hour load value
- ld_min  out  6  minute load value
- ld_seg  out  6  second load value
- ld_cs  out  7  centisecond load value; always 0
- sel  out  2  field being edited: 0 none, 1 hour, 2 minute, 3 second
- blink  out  1  display-blank toggle for the selected field

## Operation
- Edge detect: each button has a registered previous sample. An event is current=1 while previous=0. Previous-sample registers reset to 0.
- FSM states: RUN, SET_H, SET_M, SET_S, COMMIT.
  - RUN: on a set event, go to SET_H and snapshot cur_* into ld_*.
  - SET_H, then SET_M, then SET_S: each set event advances one state.
  - SET_S: a set event goes to COMMIT.
  - COMMIT: unconditionally returns to RUN after one cycle.
  - Any SET_x: an esc event goes to RUN with no load; ld_* keep their values.
- Set and esc events in the same cycle: esc wins. Esc in RUN or COMMIT is ignored.
- Snapshot clamp: captured hora >23, or min/seg >59, is stored as 0.
- Editing:
  - In SET_x, an inc event adds 1 to the selected field. Hour wraps 23→0; min/sec wrap 59→0.
  - A dec event subtracts 1. Hour wraps 0→23; min/sec wrap 0→59.
  - Inc and dec events in the same cycle: no change.
  - Inc/dec in RUN or COMMIT: ignored.
  - A step in the same cycle as a set/esc event is dropped; only the transition happens.
- Outputs by state:
  - run=1 only in RUN.
  - load=1 only in COMMIT.
  - sel = 1/2/3 in SET_H/SET_M/SET_S, else 0.
- Blink:
  - 0 in RUN and COMMIT.
  - On entry to any SET_x, blink=1 and the divider restarts.
  - Blink then toggles every BLINK_DIV cycles.
  - Any inc/dec step forces blink=1 and restarts the divider, so the edited value is visible.

## Timing
- Reset values: state RUN; run=1, load=0, ld_hora/ld_min/ld_seg/ld_cs=0, sel=0, blink=0; blink and repeat counters 0.
- Reset can be asserted mid-edit or during COMMIT. It forces the reset values immediately, with no load pulse.
- A button high at edge n after being low at edge n−1 takes effect at edge n. The new state and outputs are visible after edge n.
- Snapshot latching:
  - cur_* are sampled at the edge that leaves RUN.
  - run falls at that same edge, so the datapath counts at most on that edge.
- Commit sequence:
  - load is high for exactly one cycle, in COMMIT.
  - run=0 during COMMIT.
  - run=1 from the following cycle.
  - The datapath loads ld_* and clears centiseconds on the edge where load=1.
- ld_* are stable throughout COMMIT.
- Edit latency: one inc/dec step changes ld_* one edge after the event.

## Configuration
- Macro: AUTO_REPEAT_EN.
- Defined:
  - In SET_x, if btn_inc (or btn_dec) stays high, the first repeat step occurs REPEAT_DELAY cycles after the initial edge step.
  - Further steps follow every REPEAT_RATE cycles while the button stays held.
  - The repeat counter clears on release, on any state change, and when both buttons are high (no steps while both are high).
- Not defined: only rising edges step; holding a button produces exactly one step. REPEAT_DELAY and REPEAT_RATE are unused.

## Test plan
- Reset asserted mid-SET_M with ld_min=37 -> immediately run=1, sel=0, ld_min=0, blink=0, load stays 0.
- cur=13:45:22 in RUN, set pulse -> SET_H, ld=13:45:22, run=0, sel=1, blink=1. Then three inc + set + set + set -> exactly one load cycle with ld=16:45:22, ld_cs=0; run=1 on the next cycle.
- Wrap cases, each followed by commit:
  - SET_H at 23, one inc -> ld_hora=0.
  - SET_M at 0, one dec -> ld_min=59.
  - SET_S at 59, one inc -> ld_seg=0.
- Simultaneous events:
  - set and esc in the same cycle during SET_S -> RUN, no load.
  - inc and dec in the same cycle -> value unchanged.
- Snapshot clamp: cur_hora=30, cur_min=61 at set -> ld_hora=0, ld_min=0.
- Auto-repeat, REPEAT_DELAY=50, REPEAT_RATE=10:
  - With AUTO_REPEAT_EN defined: btn_inc held 100 cycles in SET_M from 0 -> ld_min=6 (edge step plus repeats at 50, 60, 70, 80, 90).
  - Without AUTO_REPEAT_EN: same stimulus -> ld_min=1.
